// File: rtl/regfile_read_stage.sv
// 32x64 register file with two bypassed read ports feeding the ID/EX operand register.
// One-cycle latency from address to operand; stall holds the register (kept fresh by write-back), flush squashes it.
module regfile_read_stage #(
    parameter int         DATA_WIDTH = 64,
    parameter logic [4:0] ZERO_REG   = 5'd31
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  RegWrite,
    input  logic [4:0]            WriteRegister,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic [4:0]            ReadRegister1,
    input  logic [4:0]            ReadRegister2,
    input  logic                  valid_in,
    input  logic                  stall,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] ReadData1,
    output logic [DATA_WIDTH-1:0] ReadData2,
    output logic                  valid_out,
    output logic [4:0]            rs1_q,
    output logic [4:0]            rs2_q
);

    logic [DATA_WIDTH-1:0] regs [32];
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] rd1;
    logic [DATA_WIDTH-1:0] rd2;

    assign wr_en = RegWrite && (WriteRegister != ZERO_REG);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[WriteRegister] <= WriteData;
        end
    end

    // Write-back data overrides the array so a same-cycle write is visible to the read.
    always_comb begin
        rd1 = regs[ReadRegister1];
        rd2 = regs[ReadRegister2];
        if (wr_en && (WriteRegister == ReadRegister1)) begin
            rd1 = WriteData;
        end
        if (wr_en && (WriteRegister == ReadRegister2)) begin
            rd2 = WriteData;
        end
        if (ReadRegister1 == ZERO_REG) begin
            rd1 = '0;
        end
        if (ReadRegister2 == ZERO_REG) begin
            rd2 = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ReadData1 <= '0;
            ReadData2 <= '0;
            valid_out <= 1'b0;
            rs1_q     <= 5'd0;
            rs2_q     <= 5'd0;
        end else if (flush) begin
            ReadData1 <= '0;
            ReadData2 <= '0;
            valid_out <= 1'b0;
            rs1_q     <= ZERO_REG;
            rs2_q     <= ZERO_REG;
        end else if (stall) begin
            // Held operands track write-back so they are not stale when the stall lifts.
            if (wr_en && (WriteRegister == rs1_q)) begin
                ReadData1 <= WriteData;
            end
            if (wr_en && (WriteRegister == rs2_q)) begin
                ReadData2 <= WriteData;
            end
        end else begin
            ReadData1 <= rd1;
            ReadData2 <= rd2;
            valid_out <= valid_in;
            rs1_q     <= ReadRegister1;
            rs2_q     <= ReadRegister2;
        end
    end

endmodule

// File: tb/tb_regfile_read_stage.sv
module tb_regfile_read_stage;

    typedef struct packed {
        logic [63:0] d1;
        logic [63:0] d2;
        logic        v;
        logic [4:0]  r1;
        logic [4:0]  r2;
    } out_t;

    logic        clk;
    logic        reset;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [63:0] WriteData;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic        valid_in;
    logic        stall;
    logic        flush;
    logic [63:0] ReadData1;
    logic [63:0] ReadData2;
    logic        valid_out;
    logic [4:0]  rs1_q;
    logic [4:0]  rs2_q;

    int passed;
    int fails;
    int total;

    out_t        exp_q [$];
    logic [63:0] m_regs [32];
    out_t        m_out;

    regfile_read_stage #(.DATA_WIDTH(64), .ZERO_REG(5'd31)) dut (
        .clk(clk), .reset(reset), .RegWrite(RegWrite), .WriteRegister(WriteRegister),
        .WriteData(WriteData), .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
        .valid_in(valid_in), .stall(stall), .flush(flush), .ReadData1(ReadData1),
        .ReadData2(ReadData2), .valid_out(valid_out), .rs1_q(rs1_q), .rs2_q(rs2_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input out_t e);
        check({tag, ".ReadData1"}, ReadData1, e.d1);
        check({tag, ".ReadData2"}, ReadData2, e.d2);
        check({tag, ".valid_out"}, {63'd0, valid_out}, {63'd0, e.v});
        check({tag, ".rs1_q"}, {59'd0, rs1_q}, {59'd0, e.r1});
        check({tag, ".rs2_q"}, {59'd0, rs2_q}, {59'd0, e.r2});
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
        m_out = '0;
        exp_q.delete();
    endtask

    // Reference behaviour for the upcoming edge, computed from the currently driven inputs.
    task automatic predict();
        out_t        n;
        logic        we;
        logic [63:0] r1v;
        logic [63:0] r2v;
        n   = m_out;
        we  = RegWrite && (WriteRegister != 5'd31);
        r1v = (ReadRegister1 == 5'd31) ? 64'd0 :
              (we && WriteRegister == ReadRegister1) ? WriteData : m_regs[ReadRegister1];
        r2v = (ReadRegister2 == 5'd31) ? 64'd0 :
              (we && WriteRegister == ReadRegister2) ? WriteData : m_regs[ReadRegister2];
        if (flush) begin
            n = '{d1: 64'd0, d2: 64'd0, v: 1'b0, r1: 5'd31, r2: 5'd31};
        end else if (stall) begin
            if (we && WriteRegister == m_out.r1) n.d1 = WriteData;
            if (we && WriteRegister == m_out.r2) n.d2 = WriteData;
        end else begin
            n = '{d1: r1v, d2: r2v, v: valid_in, r1: ReadRegister1, r2: ReadRegister2};
        end
        m_out = n;
        exp_q.push_back(n);
        if (we) m_regs[WriteRegister] = WriteData;
    endtask

    task automatic tick(input string tag);
        out_t e;
        predict();
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_out(tag, e);
    endtask

    task automatic drive(input logic we, input logic [4:0] wr, input logic [63:0] wd,
                         input logic [4:0] a, input logic [4:0] b, input logic v);
        RegWrite      = we;
        WriteRegister = wr;
        WriteData     = wd;
        ReadRegister1 = a;
        ReadRegister2 = b;
        valid_in      = v;
    endtask

    initial begin
        passed = 0;
        fails  = 0;
        total  = 0;
        stall  = 1'b0;
        flush  = 1'b0;
        drive(1'b0, 5'd0, 64'd0, 5'd0, 5'd0, 1'b0);
        reset = 1'b1;
        #1 reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_out("reset", m_out);
        reset = 1'b1;

        // Basic write then read, zero register on port B
        drive(1'b1, 5'd5, 64'h0000_0000_DEAD_BEEF, 5'd0, 5'd0, 1'b0);
        tick("wr_x5");
        drive(1'b0, 5'd0, 64'd0, 5'd5, 5'd31, 1'b1);
        tick("rd_x5");
        check("basic.rd1", ReadData1, 64'hDEAD_BEEF);
        check("basic.rd2", ReadData2, 64'd0);
        check("basic.valid", {63'd0, valid_out}, 64'd1);

        // Same-cycle bypass on both ports
        drive(1'b1, 5'd7, 64'h1234, 5'd7, 5'd7, 1'b1);
        tick("bypass");
        check("bypass.rd1", ReadData1, 64'h1234);
        check("bypass.rd2", ReadData2, 64'h1234);

        // Writes to XZR are discarded, including via bypass
        drive(1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd31, 1'b0);
        tick("xzr_wr");
        check("xzr.bypass", ReadData1, 64'd0);
        drive(1'b0, 5'd0, 64'd0, 5'd31, 5'd31, 1'b1);
        tick("xzr_rd");
        check("xzr.rd2", ReadData2, 64'd0);

        // Array sweep
        for (int i = 0; i < 31; i++) begin
            drive(1'b1, 5'(i), 64'(i) * 64'h0101_0101, 5'd31, 5'd31, 1'b0);
            tick("sweep_wr");
        end
        for (int i = 0; i < 31; i++) begin
            drive(1'b0, 5'd0, 64'd0, 5'(i), 5'(i), 1'b1);
            tick("sweep_rd");
        end
        check("sweep.x30", ReadData2, 64'd30 * 64'h0101_0101);

        // Stall keeps the held operand fresh
        drive(1'b1, 5'd3, 64'hA, 5'd31, 5'd31, 1'b0);
        tick("stall_prep");
        drive(1'b0, 5'd0, 64'd0, 5'd3, 5'd6, 1'b1);
        tick("stall_cap");
        check("stall.cap", ReadData1, 64'hA);
        stall = 1'b1;
        drive(1'b1, 5'd3, 64'hB, 5'd4, 5'd5, 1'b0);
        tick("stall_hold");
        check("stall.fresh", ReadData1, 64'hB);
        check("stall.rs1", {59'd0, rs1_q}, 64'd3);
        check("stall.valid", {63'd0, valid_out}, 64'd1);
        stall = 1'b0;
        drive(1'b0, 5'd0, 64'd0, 5'd4, 5'd5, 1'b1);
        tick("stall_release");
        check("release.rs1", {59'd0, rs1_q}, 64'd4);

        // Flush wins over stall; concurrent write still lands
        stall = 1'b1;
        flush = 1'b1;
        drive(1'b1, 5'd12, 64'hC0FFEE, 5'd12, 5'd12, 1'b1);
        tick("flush");
        check("flush.rs2", {59'd0, rs2_q}, 64'd31);
        check("flush.valid", {63'd0, valid_out}, 64'd0);
        stall = 1'b0;
        flush = 1'b0;
        drive(1'b0, 5'd0, 64'd0, 5'd12, 5'd3, 1'b1);
        tick("post_flush");
        check("flush.write_landed", ReadData1, 64'hC0FFEE);

        // Asynchronous reset in the middle of a write
        drive(1'b1, 5'd9, 64'h99, 5'd9, 5'd9, 1'b1);
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_out("async_reset", m_out);
        @(posedge clk);
        #1 reset = 1'b1;
        drive(1'b0, 5'd0, 64'd0, 5'd9, 5'd12, 1'b1);
        tick("after_reset");
        check("reset.x9_lost", ReadData1, 64'd0);
        check("reset.x12_cleared", ReadData2, 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
